// File: rtl/multicycle_ctrl_fsm.sv
// Main control state machine for the 16-bit multicycle RISC core.
//
// Each instruction is sequenced through FETCH / DECODE / EXEC / MEM / WB. The FSM drives
// every datapath load enable and mux select, and stops in HALT until reset.
//
// Optional feature: define RETIRE_CNT_EN to add the retired_cnt output. It is a CNT_W-bit
// count of retired instructions that wraps to 0 and is cleared by rst.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset; all outputs read 0 while it is high
//   opcode       in   Ins[15:11] from the instruction register
//   jump         in   jump class: 00 none, 01 uncond, 10 branch-if-zero, 11 branch-if-not-zero
//   zero         in   ALU zero flag, valid in EXEC
//   mem_ready    in   memory access completes this cycle
//   pc_write     out  PC load enable
//   pc_src       out  PC mux: 00 ALU (PC+1), 01 target register, 10 jump field
//   ir_write     out  instruction register load enable
//   mem_read     out  memory read strobe
//   mem_write    out  memory write strobe
//   iord         out  memory address mux: 0 PC, 1 ALU out
//   reg_write    out  register file write enable
//   mem_to_reg   out  writeback mux: 0 ALU out, 1 memory data
//   alu_src_a    out  0 PC, 1 register A
//   alu_src_b    out  00 register B, 01 constant 1, 10 sign-extended immediate
//   alu_op       out  ALU function code (000 ADD, 001 SUB, ...)
//   target_write out  branch target register load enable
//   instr_done   out  one-cycle pulse when an instruction retires
//   halted       out  high in HALT
//   state        out  current state encoding (debug)
//   retired_cnt  out  retired-instruction count (RETIRE_CNT_EN builds only)
module multicycle_ctrl_fsm #(
  parameter logic [4:0]  LOAD_OPC  = 5'b01000,
  parameter logic [4:0]  STORE_OPC = 5'b01001,
  parameter logic [4:0]  HALT_OPC  = 5'b11111,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  input  logic [1:0]       jump,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             target_write,
  output logic             instr_done,
  output logic             halted,
  output logic [2:0]       state
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StBad6   = 3'd6,
    StBad7   = 3'd7
  } state_e;

  state_e state_q, state_d;

  // Raw (ungated) control values; the ports are these values forced to 0 during reset.
  logic       pc_write_c;
  logic [1:0] pc_src_c;
  logic       ir_write_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       iord_c;
  logic       reg_write_c;
  logic       mem_to_reg_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [2:0] alu_op_c;
  logic       target_write_c;
  logic       instr_done_c;
  logic       halted_c;

  logic is_load;
  logic is_store;

  // opcode comes straight from the IR; it only changes in FETCH, so it is stable from DECODE on.
  assign is_load  = (opcode == LOAD_OPC);
  assign is_store = (opcode == STORE_OPC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_write_c     = 1'b0;
    pc_src_c       = 2'b00;
    ir_write_c     = 1'b0;
    mem_read_c     = 1'b0;
    mem_write_c    = 1'b0;
    iord_c         = 1'b0;
    reg_write_c    = 1'b0;
    mem_to_reg_c   = 1'b0;
    alu_src_a_c    = 1'b0;
    alu_src_b_c    = 2'b00;
    alu_op_c       = 3'b000;
    target_write_c = 1'b0;
    instr_done_c   = 1'b0;
    halted_c       = 1'b0;

    case (state_q)
      StFetch: begin
        // Read IR from mem[PC] while the ALU computes PC+1. The read strobe is held until ready.
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = StDecode;
        end
      end

      StDecode: begin
        // Precompute the branch target PC+imm, whether or not it is needed later.
        alu_src_b_c    = 2'b10;
        target_write_c = 1'b1;
        state_d        = (opcode == HALT_OPC) ? StHalt : StExec;
      end

      StExec: begin
        if (jump == 2'b01) begin
          pc_write_c   = 1'b1;
          pc_src_c     = 2'b10;
          instr_done_c = 1'b1;
          state_d      = StFetch;
        end else if (jump != 2'b00) begin
          // Compare A with B by subtraction; take the target on zero (10) or on non-zero (11).
          alu_src_a_c  = 1'b1;
          alu_src_b_c  = 2'b00;
          alu_op_c     = 3'b001;
          pc_write_c   = (jump == 2'b10) ? zero : ~zero;
          pc_src_c     = 2'b01;
          instr_done_c = 1'b1;
          state_d      = StFetch;
        end else if (is_load || is_store) begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = 2'b10;
          state_d     = StMem;
        end else if (opcode[4:3] == 2'b00) begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = 2'b00;
          alu_op_c    = opcode[2:0];
          state_d     = StWb;
        end else begin
          instr_done_c = 1'b1;
          state_d      = StFetch;
        end
      end

      StMem: begin
        iord_c      = 1'b1;
        mem_read_c  = is_load;
        mem_write_c = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_d = StWb;
          end else begin
            instr_done_c = 1'b1;
            state_d      = StFetch;
          end
        end
      end

      StWb: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = is_load;
        instr_done_c = 1'b1;
        state_d      = StFetch;
      end

      StHalt: begin
        halted_c = 1'b1;
      end

      default: begin
        // Unused encodings recover to FETCH with every output low.
        state_d = StFetch;
      end
    endcase
  end

  // Reset masks the outputs combinationally, so strobes drop in the same cycle rst rises.
  always_comb begin
    pc_write     = pc_write_c & ~rst;
    pc_src       = pc_src_c & {2{~rst}};
    ir_write     = ir_write_c & ~rst;
    mem_read     = mem_read_c & ~rst;
    mem_write    = mem_write_c & ~rst;
    iord         = iord_c & ~rst;
    reg_write    = reg_write_c & ~rst;
    mem_to_reg   = mem_to_reg_c & ~rst;
    alu_src_a    = alu_src_a_c & ~rst;
    alu_src_b    = alu_src_b_c & {2{~rst}};
    alu_op       = alu_op_c & {3{~rst}};
    target_write = target_write_c & ~rst;
    instr_done   = instr_done_c & ~rst;
    halted       = halted_c & ~rst;
    state        = rst ? 3'd0 : state_q;
  end

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Wraps naturally from all-ones to 0. HALT never retires, so the count freezes there.
  always_comb begin
    cnt_d = cnt_q;
    if (instr_done_c && (state_q != StHalt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign retired_cnt = cnt_q;
`else
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = CNT_W;
`endif

endmodule
